spi_word_master: RTL and testbench



---
 rtl/spi_word_master_pkg.sv | 34 +++
 rtl/spi_word_master_if.sv | 17 +
 rtl/spi_word_master_half_tick.sv | 32 +++
 rtl/spi_word_master.sv | 200 ++++++++++++++++++++
 tb/tb_spi_word_master.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_word_master_pkg.sv
// Shared definitions for the SPI word master: device codes, FSM state
// encodings and the chip-select decoder address lookup.
package spi_word_master_pkg;

    // Target device codes used by the configuration sequencers
    localparam logic [3:0] SPI_DEFAULT = 4'd0;
    localparam logic [3:0] SPI_AD5628  = 4'd1;
    localparam logic [3:0] SPI_AD9106  = 4'd2;
    localparam logic [3:0] SPI_2271A   = 4'd3;
    localparam logic [3:0] SPI_2271B   = 4'd4;

    // Frame sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_t;

    // CD74HC decoder address {A1,A0} for a device code; unknown codes map to 00
    function automatic logic [1:0] decoder_addr(input logic [3:0] code);
        logic [1:0] addr;
        case (code)
            SPI_AD5628: addr = 2'b00;
            SPI_AD9106: addr = 2'b01;
            SPI_2271A:  addr = 2'b10;
            SPI_2271B:  addr = 2'b11;
            default:    addr = 2'b00;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/spi_word_master_if.sv
// Command handshake between a configuration sequencer (master) and the
// SPI word engine (slave): word, length, level request and completion.
interface spi_word_master_if #(
    parameter int DATAWIDTH = 32,
    parameter int CNT_WIDTH = 8
);
    import spi_word_master_pkg::*;

    logic [DATAWIDTH-1:0] din;
    logic [CNT_WIDTH-1:0] n_bits;
    logic                 en;
    logic                 finished;

    modport master (output din, output n_bits, output en, input finished);
    modport slave  (input din, input n_bits, input en, output finished);

endinterface

// File: rtl/spi_word_master_half_tick.sv
// Half-period prescaler: a down-counter reloaded with CLKDIV-1 that emits a
// one-cycle tick when it reaches zero. Restart realigns it to a frame start.
module spi_half_tick
    import spi_word_master_pkg::*;
#(
    parameter int CLKDIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int             CW     = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [CW-1:0]  RELOAD = CW'(CLKDIV - 1);

    logic [CW-1:0] cnt;

    // Count down each cycle, reloading on zero or on a frame restart
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= RELOAD;
        end else if (restart || (cnt == '0)) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/spi_word_master.sv
// SPI transmit engine: sends one MSB-first word framed by cs, with
// configurable SCLK polarity/phase and divider, and a fixed decoder address.
module spi_word_master
    import spi_word_master_pkg::*;
#(
    parameter int         DATAWIDTH = 32,
    parameter int         CNT_WIDTH = 8,
    parameter int         CLKDIV    = 5,
    parameter bit         CPOL      = 1'b1,
    parameter bit         CPHA      = 1'b1,
    parameter logic [3:0] SPINAME   = 4'd2
) (
    input  logic              clk,
    input  logic              rst,
    spi_word_master_if.slave  cmd,
    output logic              sclk,
    output logic              dout,
    output logic              cs,
    output logic              A0,
    output logic              A1
);

    localparam logic [CNT_WIDTH-1:0] MAX_BITS = CNT_WIDTH'(DATAWIDTH);

    spi_state_t           state_q, state_nxt;
    logic [DATAWIDTH-1:0] sreg_q, sreg_nxt;
    logic [CNT_WIDTH-1:0] n_lat_q, n_lat_nxt;
    logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_nxt;
    logic [CNT_WIDTH-1:0] n_eff;
    logic                 sclk_q, sclk_nxt;
    logic                 dout_q, dout_nxt;
    logic                 cs_q, cs_nxt;
    logic                 fin_q, fin_nxt;
    logic                 tick;
    logic                 restart;

    assign n_eff   = (cmd.n_bits > MAX_BITS) ? MAX_BITS : cmd.n_bits;
    assign restart = (state_q == ST_IDLE) && cmd.en;

    spi_half_tick #(
        .CLKDIV (CLKDIV)
    ) u_half_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; dropping en anywhere mid-frame aborts straight to idle
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd.en) begin
                    state_nxt = (n_eff == '0) ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!cmd.en) begin
                    state_nxt = ST_IDLE;
                end else if (tick) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!cmd.en) begin
                    state_nxt = ST_IDLE;
                end else if (tick && (sclk_q == CPOL) && (bit_cnt_q == n_lat_q)) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!cmd.en) begin
                    state_nxt = ST_IDLE;
                end else if (tick) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!cmd.en) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath, driven by the transition taken
    always_comb begin
        sclk_nxt    = sclk_q;
        dout_nxt    = dout_q;
        cs_nxt      = cs_q;
        fin_nxt     = fin_q;
        sreg_nxt    = sreg_q;
        n_lat_nxt   = n_lat_q;
        bit_cnt_nxt = bit_cnt_q;
        if (state_nxt == ST_IDLE) begin
            cs_nxt   = 1'b1;
            sclk_nxt = CPOL;
            dout_nxt = 1'b0;
            fin_nxt  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sreg_nxt    = cmd.din;
                    n_lat_nxt   = n_eff;
                    bit_cnt_nxt = '0;
                    if (state_nxt == ST_DONE) begin
                        cs_nxt  = 1'b1;
                        fin_nxt = 1'b1;
                    end else begin
                        cs_nxt = 1'b0;
                        if (!CPHA) begin
                            dout_nxt = cmd.din[DATAWIDTH-1];
                            sreg_nxt = {cmd.din[DATAWIDTH-2:0], 1'b0};
                        end
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        sclk_nxt    = ~CPOL;
                        bit_cnt_nxt = CNT_WIDTH'(1);
                        if (CPHA) begin
                            dout_nxt = sreg_q[DATAWIDTH-1];
                            sreg_nxt = {sreg_q[DATAWIDTH-2:0], 1'b0};
                        end
                    end
                end
                ST_SHIFT: begin
                    if (tick && (state_nxt == ST_SHIFT)) begin
                        if (sclk_q != CPOL) begin
                            sclk_nxt = CPOL;
                            if (!CPHA && (bit_cnt_q != n_lat_q)) begin
                                dout_nxt = sreg_q[DATAWIDTH-1];
                                sreg_nxt = {sreg_q[DATAWIDTH-2:0], 1'b0};
                            end
                        end else begin
                            sclk_nxt    = ~CPOL;
                            bit_cnt_nxt = bit_cnt_q + CNT_WIDTH'(1);
                            if (CPHA) begin
                                dout_nxt = sreg_q[DATAWIDTH-1];
                                sreg_nxt = {sreg_q[DATAWIDTH-2:0], 1'b0};
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    sclk_nxt = CPOL;
                    if (state_nxt == ST_DONE) begin
                        cs_nxt   = 1'b1;
                        fin_nxt  = 1'b1;
                        dout_nxt = 1'b0;
                    end
                end
                ST_DONE: begin
                    cs_nxt  = 1'b1;
                    fin_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q    <= CPOL;
            dout_q    <= 1'b0;
            cs_q      <= 1'b1;
            fin_q     <= 1'b0;
            sreg_q    <= '0;
            n_lat_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            sclk_q    <= sclk_nxt;
            dout_q    <= dout_nxt;
            cs_q      <= cs_nxt;
            fin_q     <= fin_nxt;
            sreg_q    <= sreg_nxt;
            n_lat_q   <= n_lat_nxt;
            bit_cnt_q <= bit_cnt_nxt;
        end
    end

    assign sclk         = sclk_q;
    assign dout         = dout_q;
    assign cs           = cs_q;
    assign cmd.finished = fin_q;
    assign {A1, A0}     = decoder_addr(SPINAME);

endmodule

// File: tb/tb_spi_word_master.sv
// Directed bench for spi_word_master: a mode-3 32-bit instance (AD9106) and
// a mode-0 8-bit instance (AD5628) share one clock and reset.
module tb_spi_word_master;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_word_master_if #(.DATAWIDTH(32), .CNT_WIDTH(8)) if3 ();
    spi_word_master_if #(.DATAWIDTH(8),  .CNT_WIDTH(8)) if0 ();

    logic sclk3, dout3, cs3, a0_3, a1_3;
    logic sclk0, dout0, cs0, a0_0, a1_0;

    spi_word_master #(
        .DATAWIDTH (32), .CNT_WIDTH (8), .CLKDIV (5),
        .CPOL (1'b1), .CPHA (1'b1), .SPINAME (4'd2)
    ) dut3 (
        .clk (clk), .rst (rst), .cmd (if3),
        .sclk (sclk3), .dout (dout3), .cs (cs3), .A0 (a0_3), .A1 (a1_3)
    );

    spi_word_master #(
        .DATAWIDTH (8), .CNT_WIDTH (8), .CLKDIV (5),
        .CPOL (1'b0), .CPHA (1'b0), .SPINAME (4'd1)
    ) dut0 (
        .clk (clk), .rst (rst), .cmd (if0),
        .sclk (sclk0), .dout (dout0), .cs (cs0), .A0 (a0_0), .A1 (a1_0)
    );

    int checkCount = 0;
    int errorCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit useM0, input logic [31:0] din, input logic [7:0] nbits);
        @(posedge clk);
        #1;
        if (useM0) begin
            if0.din    = din[7:0];
            if0.n_bits = nbits;
            if0.en     = 1'b1;
        end else begin
            if3.din    = din;
            if3.n_bits = nbits;
            if3.en     = 1'b1;
        end
    endtask

    task automatic sampleOutputs(input bit useM0, output logic s_cs, output logic s_sclk,
                                 output logic s_dout, output logic s_fin);
        s_cs   = useM0 ? cs0 : cs3;
        s_sclk = useM0 ? sclk0 : sclk3;
        s_dout = useM0 ? dout0 : dout3;
        s_fin  = useM0 ? if0.finished : if3.finished;
    endtask

    task automatic captureFrame(input bit useM0, input logic initSclk,
                                output int csLow, output int firstLow, output logic doutAtFall,
                                output int finCycle, output int rises, output logic [31:0] samples);
        logic c, s, d, f, prev;
        csLow = 0; firstLow = -1; doutAtFall = 1'b0; finCycle = -1; rises = 0; samples = '0;
        prev = initSclk;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            sampleOutputs(useM0, c, s, d, f);
            if (!c) begin
                csLow++;
                if (firstLow < 0) begin
                    firstLow   = k;
                    doutAtFall = d;
                end
            end
            if (s && !prev) begin
                samples = {samples[30:0], d};
                rises++;
            end
            prev = s;
            if (f) begin
                finCycle = k;
                break;
            end
        end
    endtask

    task automatic holdAndCount(input bit useM0, input int cycles, output int csLowCnt, output int finHighCnt);
        logic c, s, d, f;
        csLowCnt = 0; finHighCnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            sampleOutputs(useM0, c, s, d, f);
            if (!c) csLowCnt++;
            if (f)  finHighCnt++;
        end
    endtask

    task automatic dropEnable(input bit useM0, input string tag);
        logic c, s, d, f;
        if (useM0) if0.en = 1'b0; else if3.en = 1'b0;
        @(posedge clk);
        #1;
        sampleOutputs(useM0, c, s, d, f);
        checkOutput({tag, "_fin_after_drop"}, 32'(f), 32'd0);
        checkOutput({tag, "_cs_after_drop"},  32'(c), 32'd1);
    endtask

    task automatic runFullFrame(input bit useM0, input logic initSclk, input logic [31:0] din,
                                input logic [7:0] nbits, input logic [31:0] expSamples,
                                input int expRises, input int expCsLow, input int expFin,
                                input string tag, output logic doutAtFall);
        int csLow, firstLow, finCycle, rises, csLowHold, finHold;
        logic [31:0] samples;
        applyStimulus(useM0, din, nbits);
        captureFrame(useM0, initSclk, csLow, firstLow, doutAtFall, finCycle, rises, samples);
        checkOutput({tag, "_samples"},  samples, expSamples);
        checkOutput({tag, "_rises"},    32'(rises), 32'(expRises));
        checkOutput({tag, "_cs_low"},   32'(csLow), 32'(expCsLow));
        checkOutput({tag, "_cs_fall"},  32'(firstLow), 32'd1);
        checkOutput({tag, "_fin_cyc"},  32'(finCycle), 32'(expFin));
        holdAndCount(useM0, 40, csLowHold, finHold);
        checkOutput({tag, "_no_refire"}, 32'(csLowHold), 32'd0);
        checkOutput({tag, "_fin_held"},  32'(finHold), 32'd40);
        dropEnable(useM0, tag);
    endtask

    initial begin
        logic dfall;
        int csLowCnt, finHighCnt;

        rst = 1'b1;
        if3.din = '0; if3.n_bits = '0; if3.en = 1'b0;
        if0.din = '0; if0.n_bits = '0; if0.en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cs3",   32'(cs3),   32'd1);
        checkOutput("rst_sclk3", 32'(sclk3), 32'd1);
        checkOutput("rst_dout3", 32'(dout3), 32'd0);
        checkOutput("rst_fin3",  32'(if3.finished), 32'd0);
        checkOutput("rst_addr3", 32'({a1_3, a0_3}), 32'd1);
        checkOutput("rst_cs0",   32'(cs0),   32'd1);
        checkOutput("rst_sclk0", 32'(sclk0), 32'd0);
        checkOutput("rst_addr0", 32'({a1_0, a0_0}), 32'd0);
        rst = 1'b0;

        runFullFrame(1'b0, 1'b1, 32'hF8000001, 8'd32, 32'hF8000001, 32, 330, 331, "m3_n32", dfall);
        runFullFrame(1'b0, 1'b1, 32'hABCDEF00, 8'd24, 32'h00ABCDEF, 24, 250, 251, "m3_n24", dfall);

        checkOutput("m0_sclk_idle", 32'(sclk0), 32'd0);
        runFullFrame(1'b1, 1'b0, 32'h000000A5, 8'd8, 32'h000000A5, 8, 90, 91, "m0_a5", dfall);
        checkOutput("m0_dout_at_cs_fall", 32'(dfall), 32'd1);

        applyStimulus(1'b0, 32'hFFFFFFFF, 8'd32);
        repeat (100) @(posedge clk);
        #1;
        checkOutput("abort_pre_cs",   32'(cs3),   32'd0);
        checkOutput("abort_pre_sclk", 32'(sclk3), 32'd0);
        checkOutput("abort_pre_dout", 32'(dout3), 32'd1);
        if3.en = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_cs",   32'(cs3),   32'd1);
        checkOutput("abort_sclk", 32'(sclk3), 32'd1);
        checkOutput("abort_dout", 32'(dout3), 32'd0);
        checkOutput("abort_fin",  32'(if3.finished), 32'd0);
        holdAndCount(1'b0, 30, csLowCnt, finHighCnt);
        checkOutput("abort_fin_never", 32'(finHighCnt), 32'd0);
        runFullFrame(1'b0, 1'b1, 32'h12345678, 8'd32, 32'h12345678, 32, 330, 331, "fresh", dfall);

        applyStimulus(1'b0, 32'hF8000001, 8'd32);
        repeat (27) @(posedge clk);
        #1;
        checkOutput("rstmid_pre_cs",   32'(cs3),   32'd0);
        checkOutput("rstmid_pre_sclk", 32'(sclk3), 32'd0);
        checkOutput("rstmid_pre_dout", 32'(dout3), 32'd1);
        rst = 1'b1;
        if3.en = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstmid_cs",   32'(cs3),   32'd1);
        checkOutput("rstmid_sclk", 32'(sclk3), 32'd1);
        checkOutput("rstmid_dout", 32'(dout3), 32'd0);
        checkOutput("rstmid_fin",  32'(if3.finished), 32'd0);
        checkOutput("rstmid_addr", 32'({a1_3, a0_3}), 32'd1);
        rst = 1'b0;
        holdAndCount(1'b0, 10, csLowCnt, finHighCnt);
        checkOutput("rstmid_idle_cs",  32'(csLowCnt), 32'd0);
        checkOutput("rstmid_idle_fin", 32'(finHighCnt), 32'd0);

        applyStimulus(1'b0, 32'hFFFFFFFF, 8'd0);
        @(posedge clk);
        #1;
        checkOutput("n0_fin", 32'(if3.finished), 32'd1);
        checkOutput("n0_cs",  32'(cs3), 32'd1);
        holdAndCount(1'b0, 20, csLowCnt, finHighCnt);
        checkOutput("n0_cs_never", 32'(csLowCnt), 32'd0);
        checkOutput("n0_fin_held", 32'(finHighCnt), 32'd20);
        dropEnable(1'b0, "n0");

        runFullFrame(1'b0, 1'b1, 32'hC3A50F96, 8'd40, 32'hC3A50F96, 32, 330, 331, "n40", dfall);
        checkOutput("final_addr3", 32'({a1_3, a0_3}), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
